fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage, directly upstream of the control logic and datapath.
//   - Owns the PC and issues word requests to instruction memory over a req/gnt/rvalid handshake.
//   - Buffers returned words in a small FIFO and presents one instruction per cycle on inst_o.
//   - Inserts NOP bubbles (32'h0000_0000, opcode 0) on stall, on empty buffer and on redirect.
//   - Redirects the PC on pc_sel_i.
// PARAMETERS
//   RESET_PC    32'h0000_0000  first fetch address after reset
//   FIFO_DEPTH  2              instruction buffer entries; power of two, >=2
// PORTS
//   clk            in   1   main clock, all state on rising edge
//   rst            in   1   asynchronous active-high reset
//   pc_sel_i       in   1   redirect request from control logic; target is alu_target_i
//   alu_target_i   in   32  branch/jump target from ALU
//   stall_i        in   1   hold buffer head, emit NOP
//   imem_req_o     out  1   fetch request valid
//   imem_addr_o    out  32  fetch address, word aligned
//   imem_gnt_i     in   1   request accepted this cycle
//   imem_rvalid_i  in   1   read data valid (one per granted request, in order)
//   imem_rdata_i   in   32  read data
//   inst_o         out  32  instruction to decode (NOP when inst_valid_o=0)
//   inst_valid_o   out  1   inst_o is a real fetched instruction
//   pc_o           out  32  PC of inst_o (0 when inst_valid_o=0)
// BEHAVIOUR
//   Reset (async):
//     - fetch_pc=RESET_PC; FIFO empty; state=S_IDLE; outstanding=0.
//     - Outputs: imem_req_o=0, imem_addr_o=RESET_PC, inst_o=0, inst_valid_o=0, pc_o=0.
//   Reset mid-transaction: outstanding request abandoned; a late rvalid in S_IDLE is ignored.
//   FSM:
//     - S_IDLE -> S_REQ one cycle after rst deasserts.
//     - S_REQ: imem_req_o=1 iff fifo_count+outstanding < FIFO_DEPTH; addr=fetch_pc.
//       On gnt: outstanding=1, fetch_pc+=4 (mod 2^32, FFFF_FFFC wraps to 0), go S_WAIT.
//     - S_WAIT: imem_req_o=0. On rvalid: push {fetch addr, rdata}, go S_REQ.
//     - S_DRAIN: imem_req_o=0. On rvalid: discard the word, go S_REQ.
//     - Max one outstanding request.
//   Redirect (pc_sel_i=1), takes priority over all else:
//     - FIFO flushed at the edge; fetch_pc = {alu_target_i[31:2],2'b00}.
//     - inst_o=NOP, inst_valid_o=0 in the redirect cycle.
//     - Outstanding request, or gnt in the same cycle: -> S_DRAIN, else -> S_REQ.
//     - rvalid in the redirect cycle: word dropped, -> S_REQ.
//     - Redirect while already in S_DRAIN: stay in S_DRAIN, update fetch_pc.
//   Output:
//     - inst_o/pc_o/inst_valid_o combinational from FIFO head when !empty && !stall_i
//       && !pc_sel_i, else NOP/0/0.
//     - Pop when inst_valid_o=1.
//     - No rdata bypass: a word is visible on inst_o at the earliest the cycle after its rvalid.
//   FIFO boundaries:
//     - Push and pop in the same cycle at full are legal; count unchanged.
//     - Push never occurs when full (guaranteed by the request gating).
//     - stall_i with empty FIFO: NOP, fetching continues.
//   Latency: gnt in cycle N, rvalid in N+1 -> inst_o valid in N+2.
// TESTING
//   1. Reset release, gnt same cycle, rvalid next, rdata=32'h0000_0093
//      -> addr 0,4,8..., inst_o=32'h93 with pc_o=0 two cycles after gnt.
//   2. stall_i=1 for 3 cycles with FIFO full (DEPTH=2)
//      -> inst_o=0 during stall, imem_req_o=0, then instructions @0,@4 emitted in order.
//   3. pc_sel_i=1, alu_target_i=32'h0000_0102 while a request is outstanding
//      -> returned word discarded, next imem_addr_o=32'h0000_0100.
//   4. pc_sel_i and imem_rvalid_i in the same cycle
//      -> word dropped, FIFO empty, inst_valid_o=0, next fetch at target.
//   5. fetch_pc=32'hFFFF_FFFC granted -> next imem_addr_o=32'h0000_0000.
//   6. rst asserted in S_WAIT, rvalid arrives during reset
//      -> no push; after release first imem_addr_o=RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// req/addr/gnt form the request handshake; rvalid/rdata carry the in-order reply.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one imem request in
// flight, buffers returned words in a small FIFO and hands one instruction per
// cycle to decode. Emits NOP bubbles on stall, empty buffer and redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_sel_i,
    input  logic [31:0]       alu_target_i,
    input  logic              stall_i,
    fetch_unit_if.master      imem_if,
    output logic [31:0]       inst_o,
    output logic              inst_valid_o,
    output logic [31:0]       pc_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      fifo_inst_q [FIFO_DEPTH];
    logic [31:0]      fifo_pc_q   [FIFO_DEPTH];

    logic fifo_empty;
    logic req;
    logic gnt_acc;
    logic push;
    logic pop;

    // Request gating, handshake qualification and the NOP-or-head output mux.
    always_comb begin
        fifo_empty   = (count_q == '0);
        // Outstanding is implied by S_WAIT/S_DRAIN, so in S_REQ only the FIFO occupancy gates.
        req          = (state_q == S_REQ) && (count_q < DEPTH_C);
        gnt_acc      = req && imem_if.imem_gnt;
        // Words only enter the FIFO on the edge after rvalid, so there is no rdata bypass.
        push         = (state_q == S_WAIT) && imem_if.imem_rvalid && !pc_sel_i;
        inst_valid_o = !fifo_empty && !stall_i && !pc_sel_i;
        pop          = inst_valid_o;
        inst_o       = inst_valid_o ? fifo_inst_q[rd_ptr_q] : 32'h0000_0000;
        pc_o         = inst_valid_o ? fifo_pc_q[rd_ptr_q]   : 32'h0000_0000;
    end

    assign imem_if.imem_req  = req;
    assign imem_if.imem_addr = fetch_pc_q;

    // Next-state logic for the fetch FSM and PC; redirect overrides everything.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ: begin
                if (gnt_acc) begin
                    state_d    = S_WAIT;
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            S_WAIT:  if (imem_if.imem_rvalid) state_d = S_REQ;
            S_DRAIN: if (imem_if.imem_rvalid) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
        if (pc_sel_i) begin
            fetch_pc_d = {alu_target_i[31:2], 2'b00};
            // A reply still owed (or just granted) must be swallowed before refetching.
            if (gnt_acc ||
                (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !imem_if.imem_rvalid)) begin
                state_d = S_DRAIN;
            end else begin
                state_d = S_REQ;
            end
        end
    end

    // FSM state and PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    // FIFO pointers and occupancy; a redirect flushes the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (pc_sel_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful under the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst_q[wr_ptr_q] <= imem_if.imem_rdata;
            fifo_pc_q[wr_ptr_q]   <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: cycle table for the directed scenarios, hand
// sequences for PC wrap and reset mid-transaction, then a randomized run
// against a program-order reference model with a simple imem responder.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_sel_i = 1'b0;
    logic        stall_i = 1'b0;
    logic [31:0] alu_target_i = 32'h0;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic [31:0] pc_o;

    int checks = 0;
    int errors = 0;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_sel_i    (pc_sel_i),
        .alu_target_i(alu_target_i),
        .stall_i     (stall_i),
        .imem_if     (bus),
        .inst_o      (inst_o),
        .inst_valid_o(inst_valid_o),
        .pc_o        (pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        stall;
        logic        pc_sel;
        logic [31:0] target;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd,
                                input logic st, input logic ps, input logic [31:0] tg,
                                input logic ereq, input logic [31:0] eaddr,
                                input logic ev, input logic [31:0] einst,
                                input logic [31:0] epc);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.rdata = rd; v.stall = st; v.pc_sel = ps;
        v.target = tg; v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = ev;
        v.exp_inst = einst; v.exp_pc = epc;
        return v;
    endfunction

    // Memory contents as a function of address for the randomized run.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                         input logic st, input logic ps, input logic [31:0] tg);
        bus.imem_gnt    = g;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rd;
        stall_i         = st;
        pc_sel_i        = ps;
        alu_target_i    = tg;
    endtask

    // Leaves the bench at a negedge with rst just released.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    logic        pend;
    logic [31:0] pend_addr;
    int          dly;
    logic [31:0] exp_fetch;
    logic [31:0] exp_emit;
    int          emitted;
    logic        rv;
    logic        acc;

    initial begin
        drive(0, 0, 0, 0, 0, 0);

        // Reset state
        @(negedge clk);
        #1;
        check("rst_req",   {31'b0, bus.imem_req}, 32'h0);
        check("rst_addr",  bus.imem_addr, 32'h0);
        check("rst_valid", {31'b0, inst_valid_o}, 32'h0);
        check("rst_inst",  inst_o, 32'h0);
        check("rst_pc",    pc_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        //           gnt rv rdata          st ps target        req addr          v inst           pc
        tbl.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,       0, 32'h0,       0, 32'h0,         32'h0));
        tbl.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,       1, 32'h0,       0, 32'h0,         32'h0));
        tbl.push_back(mk(1, 1, 32'h0000_0093, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,         32'h0));
        tbl.push_back(mk(1, 0, 32'h0,         1, 0, 32'h0,       1, 32'h4,       0, 32'h0,         32'h0));
        tbl.push_back(mk(1, 1, 32'h0000_0113, 1, 0, 32'h0,       0, 32'h0,       0, 32'h0,         32'h0));
        tbl.push_back(mk(1, 0, 32'h0,         1, 0, 32'h0,       0, 32'h0,       0, 32'h0,         32'h0));
        tbl.push_back(mk(1, 0, 32'h0,         1, 0, 32'h0,       0, 32'h0,       0, 32'h0,         32'h0));
        tbl.push_back(mk(1, 0, 32'h0,         1, 0, 32'h0,       0, 32'h0,       0, 32'h0,         32'h0));
        tbl.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,       0, 32'h0,       1, 32'h0000_0093, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,       1, 32'h8,       1, 32'h0000_0113, 32'h4));
        tbl.push_back(mk(0, 0, 32'h0,         0, 1, 32'h102,     0, 32'h0,       0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,         32'h0));
        tbl.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,       1, 32'h100,     0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0293, 1, 0, 32'h0,       0, 32'h0,       0, 32'h0,         32'h0));
        tbl.push_back(mk(1, 0, 32'h0,         1, 0, 32'h0,       1, 32'h104,     0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0313, 0, 1, 32'h200,     0, 32'h0,       0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,       1, 32'h200,     0, 32'h0,         32'h0));
        tbl.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,       1, 32'h200,     0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0393, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,       1, 32'h204,     1, 32'h0000_0393, 32'h200));
        tbl.push_back(mk(1, 0, 32'h0,         1, 0, 32'h0,       1, 32'h204,     0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 1, 32'h0000_0413, 0, 0, 32'h0,       0, 32'h0,       0, 32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,       1, 32'h208,     1, 32'h0000_0413, 32'h204));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].gnt, tbl[i].rvalid, tbl[i].rdata, tbl[i].stall, tbl[i].pc_sel, tbl[i].target);
            #1;
            check($sformatf("tbl%0d_req", i), {31'b0, bus.imem_req}, {31'b0, tbl[i].exp_req});
            if (tbl[i].exp_req)
                check($sformatf("tbl%0d_addr", i), bus.imem_addr, tbl[i].exp_addr);
            check($sformatf("tbl%0d_valid", i), {31'b0, inst_valid_o}, {31'b0, tbl[i].exp_valid});
            check($sformatf("tbl%0d_inst", i), inst_o, tbl[i].exp_inst);
            check($sformatf("tbl%0d_pc", i), pc_o, tbl[i].exp_pc);
            @(negedge clk);
        end

        // PC wrap: redirect to the last word, fetch it, next address wraps to 0.
        drive(0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        #1; check("wrap_redirect_valid", {31'b0, inst_valid_o}, 32'h0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0);
        #1; check("wrap_req", {31'b0, bus.imem_req}, 32'h1);
        check("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        drive(0, 1, 32'h0000_0513, 0, 0, 0);
        #1; check("wrap_wait_req", {31'b0, bus.imem_req}, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1; check("wrap_addr_zero", bus.imem_addr, 32'h0);
        check("wrap_req2", {31'b0, bus.imem_req}, 32'h1);
        check("wrap_valid", {31'b0, inst_valid_o}, 32'h1);
        check("wrap_pc", pc_o, 32'hFFFF_FFFC);
        check("wrap_inst", inst_o, 32'h0000_0513);
        @(negedge clk);

        // Reset while a request is outstanding; the late reply must be ignored.
        drive(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1, 32'h0000_0613, 0, 0, 0);
        #1; check("rstmid_req", {31'b0, bus.imem_req}, 32'h0);
        check("rstmid_addr", bus.imem_addr, 32'h0);
        check("rstmid_valid", {31'b0, inst_valid_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1; check("rstmid_idle_req", {31'b0, bus.imem_req}, 32'h0);
        @(negedge clk);
        #1; check("rstmid_first_req", {31'b0, bus.imem_req}, 32'h1);
        check("rstmid_first_addr", bus.imem_addr, 32'h0);
        check("rstmid_no_push", {31'b0, inst_valid_o}, 32'h0);
        @(negedge clk);
        #1; check("rstmid_no_push2", {31'b0, inst_valid_o}, 32'h0);

        // Randomized run against the program-order model.
        do_reset();
        pend = 1'b0; pend_addr = 32'h0; dly = 0;
        exp_fetch = 32'h0; exp_emit = 32'h0; emitted = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rv = pend && (dly == 0);
            bus.imem_rvalid = rv;
            bus.imem_rdata  = rv ? memf(pend_addr) : $urandom;
            bus.imem_gnt    = ($urandom_range(0, 9) < 6);
            stall_i         = ($urandom_range(0, 3) == 0);
            pc_sel_i        = ($urandom_range(0, 24) == 0);
            alu_target_i    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                          : $urandom;
            #1;
            if (pend) check("rnd_one_outstanding", {31'b0, bus.imem_req}, 32'h0);
            if (stall_i || pc_sel_i) check("rnd_bubble", {31'b0, inst_valid_o}, 32'h0);
            if (!inst_valid_o) begin
                check("rnd_nop_inst", inst_o, 32'h0);
                check("rnd_nop_pc", pc_o, 32'h0);
            end else begin
                check("rnd_emit_pc", pc_o, exp_emit);
                check("rnd_emit_inst", inst_o, memf(exp_emit));
                exp_emit = exp_emit + 32'd4;
                emitted++;
            end
            acc = bus.imem_req && bus.imem_gnt;
            if (acc && !pc_sel_i) begin
                check("rnd_fetch_addr", bus.imem_addr, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
            end
            if (pc_sel_i) begin
                exp_fetch = {alu_target_i[31:2], 2'b00};
                exp_emit  = {alu_target_i[31:2], 2'b00};
            end
            if (rv) pend = 1'b0;
            else if (pend) dly--;
            if (acc) begin
                pend      = 1'b1;
                pend_addr = bus.imem_addr;
                dly       = $urandom_range(0, 2);
            end
            @(negedge clk);
        end
        check("rnd_progress", {31'b0, (emitted >= 100)}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
